tiny_nn_seq: RTL and testbench
==============================

Name: tiny_nn_seq

Overview:
- Parametrised command sequencer for the tiny_nn datapath. Generalises the fixed 4x2 convolve controller to any ValArrayWidth x ValArrayHeight array.
- Decodes 16-bit command words, streams W*H parameters into the core, then sequences row-by-row convolve execution.
- Adds a parameter-reuse command and serialises the 16-bit accumulate result onto the 8-bit output.
- Sits between the chip pins (data_i/data_o) and tiny_nn_core; all core controls are ports, so the block verifies stand-alone.

Parameters:
- CountWidth, 12, width of the window-count field in the command word; legal range 1..12.
- ValArrayWidth, 4, value-array columns (W); legal range >=1.
- ValArrayHeight, 2, value-array rows (H); legal range >=2.
- RowW, $clog2(ValArrayHeight), localparam, row index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- data_i  in  16  command word, or parameter/value data.
- data_o  out  8  result byte stream; 8'hFF when not emitting.
- param_write_o  out  W*H  one-hot parameter write strobe to core.
- val_shift_o  out  H  per-row value shift strobe.
- mul_row_sel_o  out  RowW  row selected for multiply.
- mul_en_o  out  1  multiplier enable.
- acc_en_o  out  2  [0] accumulate this cycle; [1] last row of window.
- acc_i  in  16  core accumulate result (fp_t bits).
- busy_o  out  1  high whenever state != Idle.

Behaviour:
- Reset: single clock clk_i; reset rst_ni is asynchronous and active-low. Every flop resets: state=Idle, counter=0, row=0, param_write=0, params_valid=0.
- Output reset values: all control outputs 0; data_o=8'hFF; busy_o=0.
- Opcode field data_i[15:12]; count field N=data_i[CountWidth-1:0].
  - 4'h1 Convolve: load parameters, then execute.
  - 4'h2 ConvolveReuse: execute with the stored parameters.
  - All other opcodes are ignored; the block stays in Idle.
- Idle:
  - Convolve: counter<=N; param_write<=one-hot bit0; ->ParamIn.
  - ConvolveReuse with params_valid=1: counter<=N; row<=0; ->Exec.
  - ConvolveReuse with params_valid=0: ignored, stays in Idle.
- ParamIn: param_write_o is registered. The first parameter is data_i on the cycle after the command. Each cycle shifts the one-hot left by 1.
  - When bit W*H-1 is set: param_write<=0, params_valid<=1, row<=0, ->Exec.
  - Exactly W*H strobe cycles occur, in bit order 0..W*H-1.
- Exec: the window row index row_q cycles 0..H-1. Outputs are combinational from row_q:
  - mul_en_o=1; acc_en_o[0]=1.
  - acc_en_o[1]=(row_q==H-1).
  - val_shift_o=one-hot(row_q).
  - mul_row_sel_o=row_q.
- Exec row/window sequencing:
  - row_q<H-1: row_q<=row_q+1.
  - row_q==H-1: row_q<=0. If counter!=0, decrement counter; else ->Idle.
  - Total Exec cycles = (N+1)*H. The counter never wraps below 0.
- data_o in Exec:
  - row_q==0: acc_i[7:0].
  - row_q==1: acc_i[15:8].
  - Rows >=2: 8'hFF.
- data_o in Idle and ParamIn: 8'hFF.
- Commands arriving outside Idle are not decoded; data_i is treated as data.
- Parameters persist across commands; only reset clears params_valid.

Optional Feature:
- Macro: TINY_NN_SEQ_RELU_EN.
- Defined: when acc_i[15]==1 (negative fp), both emitted bytes are 8'h00 (ReLU clamp). Non-negative results pass unchanged.
- Undefined: acc_i bytes pass unmodified. No extra logic is present.

Test Plan:
- Reset, then idle with data_i=16'h0000 -> data_o=8'hFF; all controls 0; busy_o=0.
- Defaults, data_i=16'h1003 ->
  - param_write_o = 0x01,0x02,...,0x80 on cycles 1-8.
  - 8 Exec cycles with row 0,1,0,1,...; acc_en_o = 01,11 alternating.
  - acc_i=16'h3C00 gives data_o = 00,3C repeated.
  - Idle on cycle 17.
- ConvolveReuse 16'h2005 straight after reset -> ignored, busy_o=0.
- After one Convolve, 16'h2000 -> Exec on the next cycle for exactly 2 cycles; param_write_o stays 0.
- Reset asserted on the 3rd Exec cycle -> outputs 0 and data_o=8'hFF immediately. A subsequent 16'h2000 is then ignored (params_valid cleared).
- Parameters W=2, H=3, 16'h1001:
  - 6 one-hot strobes.
  - 6 Exec cycles with rows 0,1,2,0,1,2.
  - data_o=8'hFF on row 2; acc_en_o[1] set only on row 2.
- With TINY_NN_SEQ_RELU_EN defined, acc_i=16'hBC00 -> data_o=00,00. Without the macro -> 00,BC.

Source files
------------

// File: rtl/tiny_nn_seq.sv
// tiny_nn_seq: command sequencer for the tiny_nn datapath.
// Decodes 16-bit command words, streams W*H parameters into the core with a
// one-hot write strobe, then walks the value array row by row for each
// convolve window, serialising the 16-bit accumulate onto the 8-bit output.
// Optional build macro: TINY_NN_SEQ_RELU_EN clamps negative results to 0.
module tiny_nn_seq #(
  parameter int CountWidth     = 12,
  parameter int ValArrayWidth  = 4,
  parameter int ValArrayHeight = 2,
  localparam int RowW          = $clog2(ValArrayHeight),
  localparam int NumParams     = ValArrayWidth * ValArrayHeight
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [15:0]               data_i,
  output logic [7:0]                data_o,
  output logic [NumParams-1:0]      param_write_o,
  output logic [ValArrayHeight-1:0] val_shift_o,
  output logic [RowW-1:0]           mul_row_sel_o,
  output logic                      mul_en_o,
  output logic [1:0]                acc_en_o,
  input  logic [15:0]               acc_i,
  output logic                      busy_o
);

  localparam logic [3:0]      OpConvolve = 4'h1;
  localparam logic [3:0]      OpReuse    = 4'h2;
  localparam logic [RowW-1:0] LastRow    = RowW'(ValArrayHeight - 1);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    ParamIn = 2'd1,
    Exec    = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CountWidth-1:0]   counter_q;
  logic [CountWidth-1:0]   counter_d;
  logic [RowW-1:0]         row_q;
  logic [RowW-1:0]         row_d;
  logic [NumParams-1:0]    param_write_q;
  logic                    params_valid_q;
  logic [3:0]              opcode;
  logic [CountWidth-1:0]   cmdCount;
  logic                    inExec;
  logic                    lastRow;
  logic [7:0]              accLo;
  logic [7:0]              accHi;

  assign opcode    = data_i[15:12];
  assign cmdCount  = data_i[CountWidth-1:0];
  assign counter_d = counter_q - CountWidth'(1);
  assign row_d     = row_q + RowW'(1);
  assign inExec    = (state_q == Exec);
  assign lastRow   = (row_q == LastRow);

  // Command decode, parameter strobe shifting and row/window sequencing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= Idle;
      counter_q      <= '0;
      row_q          <= '0;
      param_write_q  <= '0;
      params_valid_q <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (opcode == OpConvolve) begin
            counter_q     <= cmdCount;
            param_write_q <= NumParams'(1);
            state_q       <= ParamIn;
          end else if (opcode == OpReuse && params_valid_q) begin
            counter_q <= cmdCount;
            row_q     <= '0;
            state_q   <= Exec;
          end
        end
        ParamIn: begin
          if (param_write_q[NumParams-1]) begin
            param_write_q  <= '0;
            params_valid_q <= 1'b1;
            row_q          <= '0;
            state_q        <= Exec;
          end else begin
            param_write_q <= param_write_q << 1;
          end
        end
        Exec: begin
          if (lastRow) begin
            row_q <= '0;
            if (counter_q != '0) begin
              counter_q <= counter_d;
            end else begin
              state_q <= Idle;
            end
          end else begin
            row_q <= row_d;
          end
        end
        default: begin
          state_q <= Idle;
        end
      endcase
    end
  end

`ifdef TINY_NN_SEQ_RELU_EN
  assign accLo = acc_i[15] ? 8'h00 : acc_i[7:0];
  assign accHi = acc_i[15] ? 8'h00 : acc_i[15:8];
`else
  assign accLo = acc_i[7:0];
  assign accHi = acc_i[15:8];
`endif

  // Core controls decoded from the current row while executing.
  always_comb begin
    param_write_o = param_write_q;
    busy_o        = (state_q != Idle);
    mul_en_o      = inExec;
    acc_en_o      = {inExec && lastRow, inExec};
    mul_row_sel_o = inExec ? row_q : '0;
    val_shift_o   = '0;
    if (inExec) begin
      val_shift_o = ValArrayHeight'(1) << row_q;
    end
  end

  // Result byte stream: low byte on row 0, high byte on row 1, idle pattern otherwise.
  always_comb begin
    data_o = 8'hFF;
    if (inExec) begin
      if (row_q == RowW'(0)) begin
        data_o = accLo;
      end else if (row_q == RowW'(1)) begin
        data_o = accHi;
      end
    end
  end

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Testbench for tiny_nn_seq: default 4x2 instance driven from a vector table
// through a scoreboard queue, plus hand-written reset and 2x3 sequences.
module tb_tiny_nn_seq;

  logic        clk;
  logic        rst_n;

  // Default (W=4, H=2) instance
  logic [15:0] dataIn;
  logic [15:0] accIn;
  logic [7:0]  dataOut;
  logic [7:0]  paramWrite;
  logic [1:0]  valShift;
  logic        rowSel;
  logic        mulEn;
  logic [1:0]  accEn;
  logic        busy;

  // Small (W=2, H=3) instance
  logic [15:0] dataIn2;
  logic [15:0] accIn2;
  logic [7:0]  dataOut2;
  logic [5:0]  paramWrite2;
  logic [2:0]  valShift2;
  logic [1:0]  rowSel2;
  logic        mulEn2;
  logic [1:0]  accEn2;
  logic        busy2;

  int nChecks = 0;
  int nPassed = 0;

`ifdef TINY_NN_SEQ_RELU_EN
  localparam logic [7:0] NegHi = 8'h00;
`else
  localparam logic [7:0] NegHi = 8'hBC;
`endif

  tiny_nn_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dataIn), .data_o(dataOut),
    .param_write_o(paramWrite), .val_shift_o(valShift), .mul_row_sel_o(rowSel),
    .mul_en_o(mulEn), .acc_en_o(accEn), .acc_i(accIn), .busy_o(busy)
  );

  tiny_nn_seq #(.CountWidth(12), .ValArrayWidth(2), .ValArrayHeight(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dataIn2), .data_o(dataOut2),
    .param_write_o(paramWrite2), .val_shift_o(valShift2), .mul_row_sel_o(rowSel2),
    .mul_en_o(mulEn2), .acc_en_o(accEn2), .acc_i(accIn2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] acc;
    logic [7:0]  pw;
    logic [1:0]  vs;
    logic        rs;
    logic        mul;
    logic [1:0]  ae;
    logic [7:0]  dout;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else nPassed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addIdle(input logic [15:0] din, input logic [15:0] acc);
    vecs.push_back('{din, acc, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'hFF, 1'b0});
  endtask

  task automatic addParam(input logic [15:0] din, input int k);
    vecs.push_back('{din, 16'h3C00, 8'(1 << k), 2'b00, 1'b0, 1'b0, 2'b00, 8'hFF, 1'b1});
  endtask

  task automatic addExec(input logic [15:0] din, input logic [15:0] acc, input logic r,
                         input logic [7:0] dout);
    vecs.push_back('{din, acc, 8'h00, r ? 2'b10 : 2'b01, r, 1'b1, r ? 2'b11 : 2'b01, dout, 1'b1});
  endtask

  task automatic applyStimulus();
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      dataIn = vecs[i].din;
      accIn  = vecs[i].acc;
      sb.push_back(vecs[i]);
      @(negedge clk);
      v = sb.pop_front();
      checkOutput($sformatf("v%0d_pw", i),   32'(paramWrite), 32'(v.pw));
      checkOutput($sformatf("v%0d_vs", i),   32'(valShift),   32'(v.vs));
      checkOutput($sformatf("v%0d_row", i),  32'(rowSel),     32'(v.rs));
      checkOutput($sformatf("v%0d_mul", i),  32'(mulEn),      32'(v.mul));
      checkOutput($sformatf("v%0d_acc", i),  32'(accEn),      32'(v.ae));
      checkOutput($sformatf("v%0d_dout", i), 32'(dataOut),    32'(v.dout));
      checkOutput($sformatf("v%0d_busy", i), 32'(busy),       32'(v.busy));
      tick();
    end
  endtask

  initial begin
    // Vector table: reuse-before-load, idle, bad opcode, full Convolve, Reuse
    addIdle(16'h2005, 16'h0000);
    addIdle(16'h0000, 16'h0000);
    addIdle(16'h0000, 16'h0000);
    addIdle(16'h3005, 16'h0000);
    addIdle(16'h0000, 16'h0000);
    addIdle(16'h1003, 16'h3C00);
    for (int k = 0; k < 8; k++) addParam(16'h1000 + 16'(k), k);
    for (int k = 0; k < 8; k++) addExec(16'h2001, 16'h3C00, k[0], k[0] ? 8'h3C : 8'h00);
    addIdle(16'h0000, 16'h3C00);
    addIdle(16'h2000, 16'hBC00);
    addExec(16'h0000, 16'hBC00, 1'b0, 8'h00);
    addExec(16'h0000, 16'hBC00, 1'b1, NegHi);
    addIdle(16'h0000, 16'hBC00);

    dataIn = 16'h0000; accIn = 16'h0000;
    dataIn2 = 16'h0000; accIn2 = 16'h0000;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_dout", 32'(dataOut), 32'hFF);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ctrl", {paramWrite, valShift, rowSel, mulEn, accEn}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    applyStimulus();

    // Reset asserted on the 3rd Exec cycle of a two-window Convolve
    accIn = 16'h1234;
    dataIn = 16'h1001;
    tick();
    dataIn = 16'h0000;
    repeat (10) tick();
    checkOutput("pre_rst_mul", 32'(mulEn), 32'h1);
    checkOutput("pre_rst_dout", 32'(dataOut), 32'h34);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_ctrl", {paramWrite, valShift, rowSel, mulEn, accEn}, 32'h0);
    checkOutput("mid_rst_dout", 32'(dataOut), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dataIn = 16'h2000;
    tick();
    dataIn = 16'h0000;
    checkOutput("reuse_after_rst_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("reuse_after_rst_mul", 32'(mulEn), 32'h0);

    // 2x3 array, two windows
    accIn2 = 16'h1234;
    dataIn2 = 16'h1001;
    tick();
    dataIn2 = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("s_pw%0d", i), 32'(paramWrite2), 32'(1 << i));
      checkOutput($sformatf("s_pbusy%0d", i), 32'(busy2), 32'h1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      int r;
      r = i % 3;
      checkOutput($sformatf("s_row%0d", i), 32'(rowSel2), 32'(r));
      checkOutput($sformatf("s_vs%0d", i), 32'(valShift2), 32'(1 << r));
      checkOutput($sformatf("s_acc%0d", i), 32'(accEn2), (r == 2) ? 32'h3 : 32'h1);
      checkOutput($sformatf("s_pw_x%0d", i), 32'(paramWrite2), 32'h0);
      checkOutput($sformatf("s_dout%0d", i), 32'(dataOut2),
                  (r == 0) ? 32'h34 : ((r == 1) ? 32'h12 : 32'hFF));
      tick();
    end
    checkOutput("s_end_busy", 32'(busy2), 32'h0);
    checkOutput("s_end_dout", 32'(dataOut2), 32'hFF);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
